// File: rtl/lcd_hex_writer.sv
// Writes a value as NIBBLES uppercase hex characters to an HD44780-style LCD: one address command, then digits MSD first.
// Transfers at edges t+1..t+NIBBLES+1 after acceptance at t; downstream stalls freeze the offered byte and the sequence.
module lcd_hex_writer #(
   parameter int NIBBLES = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_value,
   input  logic        i_req_line,
   input  logic [3:0]  i_req_col,
   output logic        o_byte_valid,
   input  logic        i_byte_ready,
   output logic [7:0]  o_byte_data,
   output logic        o_byte_rs,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SET_ADDR,
      S_DIGIT
   } state_t;

   localparam logic [2:0] K_FIRST = 3'(NIBBLES - 1);

   state_t      state_q, state_d;
   logic [31:0] value_q, value_d;
   logic        line_q, line_d;
   logic [3:0]  col_q, col_d;
   logic [2:0]  k_q, k_d;
   logic        done_q, done_d;

   logic        xfer;
   logic [3:0]  nib;
   logic [7:0]  ascii;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         value_q <= '0;
         line_q  <= 1'b0;
         col_q   <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         line_q  <= line_d;
         col_q   <= col_d;
         k_q     <= k_d;
         done_q  <= done_d;
      end
   end

   // Outputs decode straight from state, so an async reset drops them without waiting for an edge.
   always_comb begin
      nib          = 4'(value_q >> {k_q, 2'b00});
      ascii        = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      o_req_ready  = (state_q == S_IDLE);
      o_busy       = (state_q != S_IDLE);
      o_byte_valid = (state_q != S_IDLE);
      o_byte_rs    = (state_q == S_DIGIT);
      o_done       = done_q;
      xfer         = o_byte_valid && i_byte_ready;
      case (state_q)
         S_SET_ADDR: o_byte_data = {1'b1, line_q, 2'b00, col_q};
         S_DIGIT:    o_byte_data = ascii;
         default:    o_byte_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      line_d  = line_q;
      col_d   = col_q;
      k_d     = k_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               value_d = i_req_value;
               line_d  = i_req_line;
               col_d   = i_req_col;
               state_d = S_SET_ADDR;
            end
         end
         S_SET_ADDR: begin
            if (xfer) begin
               k_d     = K_FIRST;
               state_d = S_DIGIT;
            end
         end
         S_DIGIT: begin
            if (xfer) begin
               if (k_q == 3'd0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  k_d = k_q - 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed and randomized checks of lcd_hex_writer against a queue-based reference of the expected LCD byte stream.
module tb_lcd_hex_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rv, rr, rline, bv, brs, busy, done;
   logic        br = 1'b1;
   logic [31:0] rval;
   logic [3:0]  rcol;
   logic [7:0]  bd;
   logic        rv2, rr2, rline2, bv2, brs2, busy2, done2;
   logic        br2 = 1'b1;
   logic [31:0] rval2;
   logic [3:0]  rcol2;
   logic [7:0]  bd2;

   lcd_hex_writer #(.NIBBLES(8)) u_dut8 (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(rv), .o_req_ready(rr), .i_req_value(rval), .i_req_line(rline), .i_req_col(rcol),
      .o_byte_valid(bv), .i_byte_ready(br), .o_byte_data(bd), .o_byte_rs(brs),
      .o_busy(busy), .o_done(done)
   );

   lcd_hex_writer #(.NIBBLES(2)) u_dut2 (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(rv2), .o_req_ready(rr2), .i_req_value(rval2), .i_req_line(rline2), .i_req_col(rcol2),
      .o_byte_valid(bv2), .i_byte_ready(br2), .o_byte_data(bd2), .o_byte_rs(brs2),
      .o_busy(busy2), .o_done(done2)
   );

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   int rmode = 0;
   int stab_err = 0;
   string hx;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   logic [8:0] obs2_q[$];
   int obs_e[$], obs2_e[$], done_e[$], done2_e[$], acc_e[$], vlow_e[$], rdyhi_e[$];

   // Edge counter and downstream ready pattern (0: always, 1: one cycle in three, 2: random).
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rmode)
         0:       br = 1'b1;
         1:       br = (cyc % 3 == 0);
         default: br = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: at the falling edge, record what will happen at the next rising edge.
   initial begin
      logic       stall_p;
      logic [8:0] stall_v;
      stall_p = 1'b0;
      stall_v = '0;
      forever begin
         @(negedge clk);
         if (bv && br) begin obs_q.push_back({brs, bd}); obs_e.push_back(cyc + 1); end
         if (!bv) vlow_e.push_back(cyc);
         if (rr && !rst) rdyhi_e.push_back(cyc);
         if (rv && rr && !rst) acc_e.push_back(cyc + 1);
         if (done) done_e.push_back(cyc);
         if (stall_p && bv && ({brs, bd} !== stall_v)) stab_err++;
         stall_p = bv && !br;
         stall_v = {brs, bd};
         if (bv2 && br2) begin obs2_q.push_back({brs2, bd2}); obs2_e.push_back(cyc + 1); end
         if (done2) done2_e.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      ncmp++;
      assert (got === want) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Reference: address command 0x80 + 0x40*line + col, then hex characters MSD first.
   function automatic void model(input logic [31:0] v, input logic l, input logic [3:0] c, input int n);
      int d;
      exp_q.push_back(9'(128 + 64 * int'(l) + int'(c)));
      for (int i = n - 1; i >= 0; i--) begin
         d = int'((v >> (4 * i)) % 16);
         exp_q.push_back({1'b1, 8'(hx[d])});
      end
   endfunction

   task automatic clr();
      exp_q.delete(); obs_q.delete(); obs_e.delete(); done_e.delete(); acc_e.delete();
      vlow_e.delete(); rdyhi_e.delete(); obs2_q.delete(); obs2_e.delete(); done2_e.delete();
      stab_err = 0;
   endtask

   task automatic issue(input logic [31:0] v, input logic l, input logic [3:0] c, input string tag);
      bit seen = 0;
      @(posedge clk); #1;
      rv = 1'b1; rval = v; rline = l; rcol = c;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rr) begin seen = 1; break; end
      end
      chk({tag, "_accept"}, 32'(seen), 32'd1);
      @(posedge clk); #1;
      rv = 1'b0; rval = $urandom; rline = 1'($urandom); rcol = 4'($urandom);
   endtask

   task automatic wait_done(input int n, input string tag);
      int t = 0;
      while (done_e.size() < n && t < 2000) begin @(posedge clk); t++; end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_count"}, 32'(done_e.size()), 32'(n));
   endtask

   task automatic cmp_seq(input string tag);
      chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
   endtask

   function automatic int count_in(input int q[$], input int lo, input int hi);
      int n = 0;
      foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
      return n;
   endfunction

   task automatic run_single(input logic [31:0] v, input logic l, input logic [3:0] c, input int mode, input string tag);
      int last;
      rmode = mode;
      clr();
      model(v, l, c, 8);
      issue(v, l, c, tag);
      wait_done(1, tag);
      cmp_seq(tag);
      chk({tag, "_stable"}, 32'(stab_err), 32'd0);
      if (obs_e.size() == 9 && acc_e.size() == 1 && done_e.size() == 1) begin
         last = obs_e[8];
         chk({tag, "_done_after_last"}, 32'(done_e[0]), 32'(last));
         chk({tag, "_valid_gaps"}, 32'(count_in(vlow_e, acc_e[0], last)), 32'd0);
         if (mode == 0) begin
            chk({tag, "_first_lat"}, 32'(obs_e[0]), 32'(acc_e[0] + 1));
            chk({tag, "_last_lat"}, 32'(last), 32'(acc_e[0] + 9));
         end
      end
   endtask

   initial begin
      int t;
      hx = "0123456789ABCDEF";
      rst = 1'b1;
      rv = 1'b0; rval = '0; rline = 1'b0; rcol = '0;
      rv2 = 1'b0; rval2 = '0; rline2 = 1'b0; rcol2 = '0;
      #3;
      chk("rst_valid", 32'(bv), 32'd0);
      chk("rst_data", 32'(bd), 32'd0);
      chk("rst_rs", 32'(brs), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid_n2", 32'(bv2), 32'd0);
      // A request held during reset must not be taken.
      rv = 1'b1; rval = 32'h12345678;
      repeat (3) @(posedge clk);
      chk("rst_hold_busy", 32'(busy), 32'd0);
      #1; rv = 1'b0; rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_accept", 32'(obs_q.size()), 32'd0);
      chk("idle_ready", 32'(rr), 32'd1);

      run_single(32'h1234ABCD, 1'b0, 4'd0, 0, "v1234");
      run_single(32'h00000000, 1'b1, 4'd5, 0, "zero_l1c5");
      run_single(32'hFEDCBA98, 1'b0, 4'd0, 1, "stall3");
      for (int i = 0; i < 6; i++)
         run_single($urandom, 1'($urandom), 4'($urandom), $urandom_range(0, 2), $sformatf("rnd%0d", i));

      // Back-to-back: second request held valid while the first runs.
      rmode = 0;
      clr();
      model(32'hCAFE0123, 1'b1, 4'd2, 8);
      model(32'h89ABCDEF, 1'b0, 4'd9, 8);
      @(posedge clk); #1;
      rv = 1'b1; rval = 32'hCAFE0123; rline = 1'b1; rcol = 4'd2;
      for (int n = 0; n < 2; n++) begin
         t = 0;
         do begin @(negedge clk); t++; end while (!rr && t < 2000);
         @(posedge clk); #1;
         rval = 32'h89ABCDEF; rline = 1'b0; rcol = 4'd9;
      end
      rv = 1'b0;
      wait_done(2, "b2b");
      cmp_seq("b2b");
      chk("b2b_accepts", 32'(acc_e.size()), 32'd2);
      if (acc_e.size() == 2 && done_e.size() == 2 && obs_e.size() == 18) begin
         chk("b2b_accept_on_done", 32'(acc_e[1]), 32'(done_e[0] + 1));
         chk("b2b_ready_low", 32'(count_in(rdyhi_e, acc_e[0], done_e[0])), 32'd0);
         chk("b2b_cmd_next", 32'(obs_e[9]), 32'(acc_e[1] + 1));
      end

      // Reset after the third data byte.
      rmode = 2;
      clr();
      model(32'h76543210, 1'b1, 4'd3, 8);
      issue(32'h76543210, 1'b1, 4'd3, "abort");
      t = 0;
      while (obs_q.size() < 4 && t < 2000) begin @(posedge clk); t++; end
      chk("abort_pre_bytes", 32'(obs_q.size()), 32'd4);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", 32'(bv), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_data", 32'(bd), 32'd0);
      rv = 1'b1; rval = 32'hFFFFFFFF;
      repeat (2) @(posedge clk);
      #1; rv = 1'b0; rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_e.size()), 32'd0);
      chk("abort_no_more", 32'(obs_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         chk($sformatf("abort_b%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
      run_single(32'h0F1E2D3C, 1'b0, 4'd15, 0, "after_abort");

      // Two-digit instance, column 15 start, upper value bits ignored.
      rmode = 0;
      for (int n = 0; n < 2; n++) begin
         clr();
         rval2 = (n == 0) ? 32'h000000A7 : {$urandom_range(1, 32'hFFFFFF) , 8'hA7};
         model(rval2, 1'b0, 4'd15, 2);
         @(posedge clk); #1;
         rv2 = 1'b1; rline2 = 1'b0; rcol2 = 4'd15;
         t = 0;
         do begin @(negedge clk); t++; end while (!rr2 && t < 2000);
         @(posedge clk); #1;
         rv2 = 1'b0;
         t = 0;
         while (done2_e.size() < 1 && t < 200) begin @(posedge clk); t++; end
         repeat (3) @(posedge clk);
         #1;
         chk("n2_done_count", 32'(done2_e.size()), 32'd1);
         obs_q = obs2_q;
         cmp_seq($sformatf("n2_%0d", n));
         if (obs2_e.size() == 3 && done2_e.size() == 1)
            chk("n2_done_after_last", 32'(done2_e[0]), 32'(obs2_e[2]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lcd_hex_writer.md
LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

Interface
REQ-001 Parameter NIBBLES, default 8: number of hex digits emitted per request; legal range 1..8.
REQ-002 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset, asynchronous and active-high.
REQ-004 i_req_valid  input  1  upstream display request present.
REQ-005 o_req_ready  output  1  block can accept a request.
REQ-006 i_req_value  input  32  value to display; digits taken from bits [4*NIBBLES-1:0].
REQ-007 i_req_line  input  1  LCD line: 0 = first line, 1 = second line.
REQ-008 i_req_col  input  4  starting column, 0..15.
REQ-009 o_byte_valid  output  1  byte offered to the downstream LCD byte driver.
REQ-010 i_byte_ready  input  1  downstream accepts the offered byte.
REQ-011 o_byte_data  output  8  LCD byte, command or character.
REQ-012 o_byte_rs  output  1  LCD register select: 0 = command, 1 = data.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_done  output  1  one-cycle pulse after the last digit transfers.

Function
REQ-015 The FSM SHALL have three states: IDLE, SET_ADDR and DIGIT.
REQ-016 o_req_ready SHALL equal (state == IDLE).
REQ-017 A request SHALL be accepted on a rising edge with i_req_valid && o_req_ready; acceptance captures value, line and col into internal registers and moves the FSM to SET_ADDR.
REQ-018 Inputs i_req_* SHALL be ignored except in the accept cycle; later changes do not affect the running request.
REQ-019 A byte transfer SHALL occur on a rising edge with o_byte_valid && i_byte_ready.
REQ-020 While o_byte_valid is high and i_byte_ready is low, o_byte_data and o_byte_rs SHALL hold stable.
REQ-021 In SET_ADDR, the block SHALL offer command byte 0x80 | (line ? 0x40 : 0x00) | col with rs=0, then on transfer move to DIGIT with digit index k = NIBBLES-1.
REQ-022 In DIGIT, the block SHALL offer the ASCII of nibble value[4k+3:4k] with rs=1: 0..9 map to 0x30..0x39 and 10..15 map to 0x41..0x46 (uppercase).
REQ-023 On each DIGIT transfer, k SHALL decrement; the transfer with k==0 moves the FSM to IDLE and sets o_done=1 for exactly the next cycle.
REQ-024 Bytes SHALL be emitted most significant digit first, one byte per transfer, with no gaps beyond downstream backpressure.
REQ-025 o_byte_valid SHALL go high in the cycle after acceptance and stay high continuously until the final transfer.
REQ-026 Latency: with i_byte_ready held at 1 and acceptance at edge t, transfers SHALL occur at edges t+1..t+NIBBLES+1, and o_done SHALL be high during the cycle after edge t+NIBBLES+1.
REQ-027 In the o_done cycle the block SHALL be in IDLE with o_req_ready=1, so back-to-back requests are possible.
REQ-028 Column overflow (col+NIBBLES > 16) SHALL NOT be checked or clipped; only the start address is issued.
REQ-029 A request presented while busy SHALL NOT be accepted or lost; upstream holds it until o_req_ready=1.
REQ-030 Parameter values outside 1..8 are unsupported; behaviour for them is undefined.

Reset
REQ-031 While i_reset is high: state=IDLE, o_byte_valid=0, o_byte_data=0x00, o_byte_rs=0, o_done=0, o_busy=0, k=0, and captured registers cleared to 0.
REQ-032 Reset asserted mid-request SHALL abort immediately and asynchronously; no further bytes are offered, no o_done is produced, and the next request starts again with its command byte.
REQ-033 No request SHALL be accepted on any edge while i_reset is high.

Verification
REQ-034 value=0x1234ABCD, line 0, col 0, ready=1 -> bytes 0x80, 0x31, 0x32, 0x33, 0x34, 0x41, 0x42, 0x43, 0x44; rs pattern 0,1x8; o_done one cycle after the ninth transfer.
REQ-035 value=0x00000000, line 1, col 5 -> 0xC5 (rs=0), then eight 0x30 bytes (rs=1).
REQ-036 value=0xFEDCBA98, i_byte_ready high one cycle in three -> 0x80, 0x46, 0x45, 0x44, 0x43, 0x42, 0x41, 0x39, 0x38; data/rs stable while stalled; no drop or duplicate.
REQ-037 Second request held valid during first -> o_req_ready stays 0 until the o_done cycle; second request accepted on that edge; its command byte follows with no idle byte cycle.
REQ-038 Reset pulsed after third data transfer -> o_byte_valid and o_busy drop to 0 asynchronously; no o_done; a new request after release emits its command byte first.
REQ-039 NIBBLES=2, value=0x000000A7, line 0, col 15 -> 0x8F, 0x41, 0x37; o_done after the third transfer.
